// File: rtl/bsg_manycore_timer_pkg.sv
// bsg_manycore_timer_pkg: shared state encoding and default timer address for the request timestamper
package bsg_manycore_timer_pkg;

    typedef enum logic [1:0] {E_EMPTY, E_BYPASS, E_STAMP} timestamper_state_e;

    localparam logic [15:0] timer_base_addr_gp = 16'h3AB5;

endpackage

// File: rtl/bsg_cycle_counter.sv
// bsg_cycle_counter: free-running wrapping cycle counter
// clk_i/reset_i: clock and synchronous active-high reset; ctr_r_o: count, 0 in the first cycle after reset
module bsg_cycle_counter #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic [width_p-1:0] ctr_r_o
);

    always_ff @(posedge clk_i)
        ctr_r_o <= reset_i ? '0 : ctr_r_o + 1'b1;

endmodule

// File: rtl/bsg_manycore_timestamp_regfile.sv
// bsg_manycore_timestamp_regfile: per-tag last-stamp storage with delta subtract
// w_v_i/tag_i/time_i: record time_i as tag_i's latest stamp; delta_o: time_i minus tag_i's previous stamp
module bsg_manycore_timestamp_regfile #(
    parameter int num_tags_p    = 4,
    parameter int timer_width_p = 64,
    parameter int tag_width_p   = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     w_v_i,
    input  logic [tag_width_p-1:0]   tag_i,
    input  logic [timer_width_p-1:0] time_i,
    output logic [timer_width_p-1:0] delta_o
);

    logic [timer_width_p-1:0] last_r [num_tags_p];

    // a never-stamped tag holds 0, so its first delta is the absolute time
    assign delta_o = time_i - last_r[tag_i];

    always_ff @(posedge clk_i) begin
        if (reset_i)
            for (int i = 0; i < num_tags_p; i++) last_r[i] <= '0;
        else if (w_v_i)
            last_r[tag_i] <= time_i;
    end

endmodule

// File: rtl/bsg_manycore_endpoint_request_timestamper.sv
// bsg_manycore_endpoint_request_timestamper: passes requests to the host, turning timer-window writes into multi-beat timestamp records
// request side: v_i/yumi_o with data_i, mask_i, addr_i, we_i, src_*_cord_i
// host side: v_o/rdy_i with data_o, mask_o, addr_o, we_o, src_*_cord_o, last_o (final beat of a record)
module bsg_manycore_endpoint_request_timestamper
    import bsg_manycore_timer_pkg::*;
#(
    parameter int          x_cord_width_p    = 4,
    parameter int          y_cord_width_p    = 4,
    parameter int          addr_width_p      = 20,
    parameter int          data_width_p      = 32,
    parameter int          timer_width_p     = 64,
    parameter int unsigned timer_base_addr_p = timer_base_addr_gp,
    parameter int          num_tags_p        = 4,
    parameter bit          delta_mode_p      = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      v_i,
    output logic                      yumi_o,
    input  logic [data_width_p-1:0]   data_i,
    input  logic [data_width_p/8-1:0] mask_i,
    input  logic [addr_width_p-1:0]   addr_i,
    input  logic                      we_i,
    input  logic [x_cord_width_p-1:0] src_x_cord_i,
    input  logic [y_cord_width_p-1:0] src_y_cord_i,
    output logic                      v_o,
    input  logic                      rdy_i,
    output logic [data_width_p-1:0]   data_o,
    output logic [data_width_p/8-1:0] mask_o,
    output logic [addr_width_p-1:0]   addr_o,
    output logic                      we_o,
    output logic [x_cord_width_p-1:0] src_x_cord_o,
    output logic [y_cord_width_p-1:0] src_y_cord_o,
    output logic                      last_o
);

    localparam int beats_lp      = timer_width_p / data_width_p;
    localparam int tag_width_lp  = num_tags_p > 1 ? $clog2(num_tags_p) : 1;
    localparam int beat_width_lp = beats_lp > 1 ? $clog2(beats_lp) : 1;
    localparam logic [addr_width_p:0] base_lp = (addr_width_p+1)'(timer_base_addr_p);

    timestamper_state_e state_r;
    logic [beat_width_lp-1:0] beat_r;
    logic [beats_lp-1:0][data_width_p-1:0] record_r;
    logic [data_width_p-1:0] data_r;
    logic [data_width_p/8-1:0] mask_r;
    logic [timer_width_p-1:0] ctr, stamp_val;
    logic [addr_width_p:0] addr_off;
    logic is_stamp, last_beat, xfer, done;

    bsg_cycle_counter #(.width_p(timer_width_p)) ctr_inst (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ctr_r_o (ctr)
    );

    // one extra bit keeps addresses below the base from wrapping into the window
    assign addr_off  = {1'b0, addr_i} - base_lp;
    assign is_stamp  = we_i & ({1'b0, addr_i} >= base_lp) & (addr_off < (addr_width_p+1)'(num_tags_p));
    assign last_beat = beat_r == beat_width_lp'(beats_lp - 1);
    assign xfer      = v_o & rdy_i;
    assign done      = xfer & ((state_r == E_BYPASS) | ((state_r == E_STAMP) & last_beat));
    // accepting while the held packet leaves gives one packet or beat per cycle
    assign yumi_o    = v_i & ~reset_i & ((state_r == E_EMPTY) | done);

    generate
        if (delta_mode_p) begin : g_delta
            bsg_manycore_timestamp_regfile #(
                .num_tags_p    (num_tags_p),
                .timer_width_p (timer_width_p),
                .tag_width_p   (tag_width_lp)
            ) regfile_inst (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .w_v_i   (yumi_o & is_stamp),
                .tag_i   (addr_off[tag_width_lp-1:0]),
                .time_i  (ctr),
                .delta_o (stamp_val)
            );
        end else begin : g_abs
            assign stamp_val = ctr;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= E_EMPTY;
            beat_r  <= '0;
        end else if (yumi_o) begin
            state_r <= is_stamp ? E_STAMP : E_BYPASS;
            beat_r  <= '0;
        end else if (done) begin
            state_r <= E_EMPTY;
            beat_r  <= '0;
        end else if (xfer & (state_r == E_STAMP)) begin
            beat_r  <= beat_r + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (yumi_o) begin
            record_r     <= stamp_val;
            data_r       <= data_i;
            mask_r       <= mask_i;
            addr_o       <= addr_i;
            we_o         <= we_i;
            src_x_cord_o <= src_x_cord_i;
            src_y_cord_o <= src_y_cord_i;
        end
    end

    assign v_o    = state_r != E_EMPTY;
    assign last_o = (state_r == E_BYPASS) | ((state_r == E_STAMP) & last_beat);
    assign data_o = state_r == E_STAMP ? record_r[beat_r] : data_r;
    assign mask_o = state_r == E_STAMP ? '1 : mask_r;

endmodule

// File: tb/tb_bsg_manycore_endpoint_request_timestamper.sv
// tb_bsg_manycore_endpoint_request_timestamper: scoreboard bench driving an absolute-mode and a delta-mode timestamper in lockstep
module tb_bsg_manycore_endpoint_request_timestamper;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  mask;
        logic [19:0] addr;
        logic        we;
        logic [3:0]  x;
        logic [3:0]  y;
        logic        last;
    } beat_t;

    logic clk = 0, reset_i = 1, v_i = 0, we_i = 0, rdy_i = 1;
    logic [31:0] data_i = 0;
    logic [3:0]  mask_i = 0, x_i = 0, y_i = 0;
    logic [19:0] addr_i = 0;

    logic yumi_a, va, we_a, last_a, yumi_d, vd, we_d, last_d;
    logic [31:0] data_a, data_d;
    logic [3:0]  mask_a, mask_d, xa, ya, xd, yd;
    logic [19:0] addr_a, addr_d;

    beat_t qa[$], qd[$];
    int total = 0, bad = 0;
    logic [63:0] tb_cnt = 0;
    logic [63:0] last_m [4];
    logic [63:0] acc0, acc1, acc2;

    always #5 clk = ~clk;

    always @(posedge clk) tb_cnt <= reset_i ? 64'd0 : tb_cnt + 64'd1;

    bsg_manycore_endpoint_request_timestamper #(
        .x_cord_width_p(4), .y_cord_width_p(4), .addr_width_p(20), .data_width_p(32),
        .timer_width_p(64), .timer_base_addr_p(16'h3AB5), .num_tags_p(4), .delta_mode_p(1'b0)
    ) dut_abs (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .yumi_o(yumi_a), .data_i(data_i), .mask_i(mask_i),
        .addr_i(addr_i), .we_i(we_i), .src_x_cord_i(x_i), .src_y_cord_i(y_i), .v_o(va), .rdy_i(rdy_i),
        .data_o(data_a), .mask_o(mask_a), .addr_o(addr_a), .we_o(we_a), .src_x_cord_o(xa),
        .src_y_cord_o(ya), .last_o(last_a)
    );

    bsg_manycore_endpoint_request_timestamper #(
        .x_cord_width_p(4), .y_cord_width_p(4), .addr_width_p(20), .data_width_p(32),
        .timer_width_p(64), .timer_base_addr_p(16'h3AB5), .num_tags_p(4), .delta_mode_p(1'b1)
    ) dut_dlt (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .yumi_o(yumi_d), .data_i(data_i), .mask_i(mask_i),
        .addr_i(addr_i), .we_i(we_i), .src_x_cord_i(x_i), .src_y_cord_i(y_i), .v_o(vd), .rdy_i(rdy_i),
        .data_o(data_d), .mask_o(mask_d), .addr_o(addr_d), .we_o(we_d), .src_x_cord_o(xd),
        .src_y_cord_o(yd), .last_o(last_d)
    );

    always @(negedge clk) begin
        if (!reset_i && rdy_i && va) begin
            beat_t g, e;
            g = {data_a, mask_a, addr_a, we_a, xa, ya, last_a};
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL abs_unexpected got=%h exp=none", g);
            end else begin
                e = qa.pop_front();
                if (g !== e) begin
                    bad++;
                    $display("FAIL abs_beat got=%h exp=%h", g, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_i && rdy_i && vd) begin
            beat_t g, e;
            g = {data_d, mask_d, addr_d, we_d, xd, yd, last_d};
            total++;
            if (qd.size() == 0) begin
                bad++;
                $display("FAIL dlt_unexpected got=%h exp=none", g);
            end else begin
                e = qd.pop_front();
                if (g !== e) begin
                    bad++;
                    $display("FAIL dlt_beat got=%h exp=%h", g, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic clear_model();
        qa.delete();
        qd.delete();
        for (int i = 0; i < 4; i++) last_m[i] = 64'd0;
    endtask

    task automatic do_reset();
        reset_i = 1;
        v_i = 1;
        addr_i = 20'h100;
        we_i = 0;
        clear_model();
        @(negedge clk);
        check("reset_outputs", {58'd0, va, vd, yumi_a, yumi_d, last_a, last_d}, 64'd0);
        @(posedge clk);
        #1;
        reset_i = 0;
        v_i = 0;
    endtask

    // drives one request until accepted and pushes its expected beats;
    // use_exp selects hand-computed stamp values instead of the running model
    task automatic send(input logic [19:0] a, input logic w, input logic [31:0] d, input logic [3:0] m,
                        input logic st, input logic use_exp, input logic [63:0] ea, input logic [63:0] ed,
                        output logic [63:0] acc);
        logic got;
        logic [19:0] t;
        logic [63:0] ra, rd;
        got = 0;
        acc = '1;
        addr_i = a; we_i = w; data_i = d; mask_i = m;
        x_i = x_i + 4'd1; y_i = y_i + 4'd3; v_i = 1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (yumi_a) begin
                got = 1;
                acc = tb_cnt;
                check("yumi_agree", {63'd0, yumi_d}, 64'd1);
                if (st) begin
                    t = a - 20'h3AB5;
                    ra = use_exp ? ea : tb_cnt;
                    rd = use_exp ? ed : tb_cnt - last_m[t[1:0]];
                    last_m[t[1:0]] = tb_cnt;
                    for (int b = 0; b < 2; b++) begin
                        qa.push_back({ra[b*32 +: 32], 4'hF, a, w, x_i, y_i, b == 1});
                        qd.push_back({rd[b*32 +: 32], 4'hF, a, w, x_i, y_i, b == 1});
                    end
                end else begin
                    qa.push_back({d, m, a, w, x_i, y_i, 1'b1});
                    qd.push_back({d, m, a, w, x_i, y_i, 1'b1});
                end
            end
            @(posedge clk);
            #1;
        end
        if (!got) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && (qa.size() != 0 || qd.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain", 64'(qa.size() + qd.size()), 64'd0);
    endtask

    task automatic wait_until(input logic [63:0] target);
        for (int i = 0; i < 1000 && tb_cnt != target; i++) begin
            @(posedge clk);
            #1;
        end
        check("wait_count", tb_cnt, target);
    endtask

    initial begin
        logic [63:0] snap;
        #1;
        do_reset();

        // bypass stream: three reads back to back
        rdy_i = 1;
        send(20'h100, 0, 32'hA0A0_0001, 4'hF, 0, 0, 0, 0, acc0);
        send(20'h100, 0, 32'hA0A0_0002, 4'h3, 0, 0, 0, 0, acc1);
        send(20'h100, 0, 32'hA0A0_0003, 4'hC, 0, 0, 0, 0, acc2);
        v_i = 0;
        check("bypass_gap1", acc1 - acc0, 64'd1);
        check("bypass_gap2", acc2 - acc1, 64'd1);
        drain();

        // absolute stamp; original data discarded
        send(20'h3AB5, 1, 32'hDEAD_BEEF, 4'h3, 1, 0, 0, 0, acc0);
        v_i = 0;
        drain();

        // backpressure on beat 0 with a read waiting
        rdy_i = 0;
        send(20'h3AB6, 1, 32'h1111_2222, 4'h1, 1, 0, 0, 0, acc0);
        addr_i = 20'h200; we_i = 0; data_i = 32'h5555_AAAA; mask_i = 4'hF; v_i = 1;
        @(negedge clk);
        snap = {data_a, mask_a, addr_a, va, last_a, data_d[6:0]};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_outputs", {data_a, mask_a, addr_a, va, last_a, data_d[6:0]}, snap);
            check("hold_no_yumi", {62'd0, yumi_a, va}, 64'd1);
        end
        @(posedge clk);
        #1;
        rdy_i = 1;
        send(20'h200, 0, 32'h5555_AAAA, 4'hF, 0, 0, 0, 0, acc1);
        v_i = 0;
        drain();

        // stamp then read: read accepted on the stamp's last beat
        send(20'h3AB7, 1, 32'h0, 4'h0, 1, 0, 0, 0, acc0);
        send(20'h104, 0, 32'hCAFE_F00D, 4'h6, 0, 0, 0, 0, acc1);
        v_i = 0;
        check("no_bubble", acc1 - acc0, 64'd2);
        drain();

        // window edges: base+num_tags is bypassed, reads in window bypassed, base+3 stamped
        send(20'h3AB9, 1, 32'h1234_5678, 4'h5, 0, 0, 0, 0, acc0);
        send(20'h3AB5, 0, 32'h8765_4321, 4'hA, 0, 0, 0, 0, acc0);
        send(20'h3AB4, 1, 32'h0BAD_0BAD, 4'h9, 0, 0, 0, 0, acc0);
        send(20'h3AB8, 1, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 0, acc0);
        v_i = 0;
        drain();

        // independent per-tag deltas at fixed counts
        do_reset();
        wait_until(64'd100);
        send(20'h3AB7, 1, 32'h0, 4'h0, 1, 1, 64'd100, 64'd100, acc0);
        v_i = 0;
        wait_until(64'd200);
        send(20'h3AB5, 1, 32'h0, 4'h0, 1, 1, 64'd200, 64'd200, acc0);
        v_i = 0;
        wait_until(64'd350);
        send(20'h3AB7, 1, 32'h0, 4'h0, 1, 1, 64'd350, 64'd250, acc0);
        v_i = 0;
        drain();

        // reset mid-record abandons the second beat and restarts the counter
        send(20'h3AB6, 1, 32'h0, 4'h0, 1, 0, 0, 0, acc0);
        v_i = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset_i = 1;
        clear_model();
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_drops_record", {62'd0, va, vd}, 64'd0);
        @(posedge clk);
        #1;
        reset_i = 0;
        send(20'h3AB6, 1, 32'h0, 4'h0, 1, 1, 64'd0, 64'd0, acc0);
        v_i = 0;
        check("counter_restart", acc0, 64'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_endpoint_request_timestamper.md
Name: bsg_manycore_endpoint_request_timestamper

Overview:
- Sits between the manycore endpoint request output and the host link.
- Passes ordinary request packets through a one-entry register stage.
- Recognises writes to a window of num_tags_p timer addresses. For each, it emits a multi-beat timestamp record to the host: absolute cycle count or per-tag delta.
- Generalises the single-address, fixed-64-bit, 2-beat timer endpoint in tag count, timer width, beat count and mode. Adds a last-beat marker and full throughput.

Parameters:
- x_cord_width_p, "inv": source x-coordinate width.
- y_cord_width_p, "inv": source y-coordinate width.
- addr_width_p, "inv": request address width.
- data_width_p, "inv": data width. Must be >= 32.
- timer_width_p, 64: free-running counter width. Must be a positive multiple of data_width_p.
- timer_base_addr_p, 16'h3AB5: first timer address.
- num_tags_p, 4: number of consecutive timer addresses, i.e. tags. Must be >= 1.
- delta_mode_p, 0: 0 = emit absolute time; 1 = emit time minus this tag's previous stamp.
- Derived: beats_lp = timer_width_p/data_width_p; tag_width_lp = max(1, clog2(num_tags_p)).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  request valid from endpoint.
- yumi_o  out  1  request consumed this cycle.
- data_i  in  data_width_p  request data.
- mask_i  in  data_width_p/8  byte mask.
- addr_i  in  addr_width_p  request address.
- we_i  in  1  write enable.
- src_x_cord_i  in  x_cord_width_p  source x.
- src_y_cord_i  in  y_cord_width_p  source y.
- v_o  out  1  valid to host. Never depends on rdy_i.
- rdy_i  in  1  host ready; a beat transfers when v_o & rdy_i.
- data_o  out  data_width_p  output data.
- mask_o  out  data_width_p/8  output mask.
- addr_o  out  addr_width_p  output address.
- we_o  out  1  output write enable.
- src_x_cord_o  out  x_cord_width_p  output source x.
- src_y_cord_o  out  y_cord_width_p  output source y.
- last_o  out  1  final beat of a record. Always 1 for bypass packets.

Behaviour:
- Reset values: v_o=0, yumi_o=0, last_o=0, state=E_EMPTY, beat counter 0, cycle counter 0, per-tag last-stamp registers 0. Data-path registers are don't-care while v_o=0.
- Cycle counter:
  - Increments every cycle after reset; 0 in the first cycle after reset deasserts.
  - Wraps modulo 2^timer_width_p with no flag.
- Timer request: is_stamp = we_i & (addr_i >= timer_base_addr_p) & (addr_i < timer_base_addr_p+num_tags_p). Tag = addr_i - timer_base_addr_p.
  - Reads to the window are bypassed unchanged.
- Accept rule: yumi_o = v_i & (state==E_EMPTY | (v_o & rdy_i & (state==E_BYPASS | (state==E_STAMP & last_beat)))).
  - This gives full throughput: a new packet is accepted in the same cycle the previous record's last beat transfers.
- Timestamp capture:
  - The counter value is captured in the cycle yumi_o=1 for a stamp request, so latency to host does not skew it.
  - delta_mode_p=1: the record value is captured minus last_stamp[tag], modulo 2^timer_width_p. last_stamp[tag] is updated to the captured value in the same cycle.
  - The first stamp of a tag after reset reports the absolute time.
- States:
  - E_EMPTY: nothing held. On accept, go to E_BYPASS for a bypass packet, or E_STAMP with beat=0 for a stamp.
  - E_BYPASS: registered packet presented, last_o=1.
    - Transfer with a new accept: next state per the new packet's type.
    - Transfer with no accept: go to E_EMPTY.
    - No transfer: hold all outputs stable.
  - E_STAMP: presents beat b.
    - data_o = record[b*data_width_p +: data_width_p], least-significant beat first.
    - mask_o = all ones; last_o = (b==beats_lp-1).
    - addr, we and src fields are those of the original request. The original data_i is discarded.
    - On transfer with b<beats_lp-1: b increments.
    - On transfer of the last beat: same transitions as leaving E_BYPASS, with beat reset to 0.
- Output registers load only on yumi_o. All outputs are held stable while v_o & ~rdy_i.
- Reset asserted mid-record: the record is abandoned and no further beats are emitted.
- Simultaneous stamp and new accept: the incoming stamp's capture uses the current counter, and a same-tag delta uses the just-updated last_stamp.

Decomposition:
- Shared package bsg_manycore_timer_pkg holds:
  - enum typedef timestamper_state_e {E_EMPTY, E_BYPASS, E_STAMP};
  - default timer base address constant.
- Reuse bsg_cycle_counter for the free-running count.
- One natural sub-module, bsg_manycore_timestamp_regfile:
  - num_tags_p x timer_width_p last-stamp storage with delta subtract.
  - Generated only when delta_mode_p=1.

Test Plan:
- Bypass stream: 3 back-to-back reads to 0x100, rdy_i=1 -> 3 outputs on consecutive cycles, last_o=1 each, yumi_o high 3 consecutive cycles.
- Absolute stamp: data_width_p=32, timer_width_p=64; counter=0x1_0000_0005 at accept, write to 0x3AB5, rdy_i=1 -> beats 0x00000005 then 0x00000001 with last_o on beat 2; mask_o=0xF on both.
- Backpressure: rdy_i=0 for 4 cycles during beat 0 -> v_o=1, data_o and all outputs constant, yumi_o=0. After release, both beats follow.
- Delta mode with num_tags_p=4: tag 2 stamped at counts 100 then 350, tag 0 at 200 -> records 100, 250, 200. Tags are independent.
- Back-to-back record then bypass: stamp followed immediately by a read -> read accepted in the same cycle as the stamp's last beat; no bubble between them.
- Boundary and reset: write to base+num_tags_p is bypassed unchanged. Reset asserted after beat 0 -> v_o=0 the next cycle and the counter restarts at 0.
